fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares the write side of the 16-bit, 8-deep synchronous FIFO among several producers. Each producer presents a word with a valid/ready-style `req`/`gnt` handshake. The arbiter picks one winner per cycle, registers the word onto the FIFO's `wr_en`/`data_in`, and throttles on `full`/`almostfull` so the FIFO never sees an overflowing write. It also checks the FIFO's `wr_ack`/`overflow` responses and flags any protocol violation.

---
 rtl/fifo_wr_arbiter_pkg.sv | 22 ++
 rtl/fifo_arb_rr_pick.sv | 31 +++
 rtl/fifo_wr_arbiter.sv | 115 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
// Optional statistics are enabled by defining FIFO_ARB_STATS_EN.
package fifo_wr_arbiter_pkg;

  localparam int FIFO_WIDTH = 16;
  localparam int FIFO_DEPTH = 8;
  localparam int NUM_REQ    = 4;
  localparam int BURST_LEN  = 4;

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    STALL = 2'd2
  } arb_state_e;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Rotate-priority picker: first requester at or after ptr, ascending with wrap.
// Purely combinational; gnt is one-hot or zero, win is the granted index.
module fifo_arb_rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          enable,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] win,
  output logic          valid
);

  always_comb begin
    int idx;
    gnt   = '0;
    win   = '0;
    valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (enable && !valid && req[idx]) begin
        valid = 1'b1;
        win   = PW'(idx);
      end
    end
    if (valid) gnt[win] = 1'b1;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of an 8-deep FIFO with burst limiting and response checking.
// Define FIFO_ARB_STATS_EN to add saturating grant/stall counters and their output ports.
module fifo_wr_arbiter #(
  parameter int FIFO_WIDTH = fifo_wr_arbiter_pkg::FIFO_WIDTH,
  parameter int NUM_REQ    = fifo_wr_arbiter_pkg::NUM_REQ,
  parameter int BURST_LEN  = fifo_wr_arbiter_pkg::BURST_LEN
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          wr_en,
  output logic [FIFO_WIDTH-1:0]         data_in,
  input  logic                          full,
  input  logic                          almostfull,
  input  logic                          wr_ack,
  input  logic                          overflow,
  output logic                          err
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         stat_gnt_cnt,
  output logic [15:0]                   stat_stall_cnt
`endif
);

  import fifo_wr_arbiter_pkg::*;

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BURST_LEN + 1);

  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      last_win;
  logic [PW-1:0]      win;
  logic [CW-1:0]      burst_cnt;
  logic [CW-1:0]      next_cnt;
  logic [NUM_REQ-1:0] pick_gnt;
  logic               pick_valid;
  logic               blocked;
  logic               exp_ack;
  arb_state_e         state;

  // The in-flight write lands the last free slot when almostfull is already up.
  assign blocked = full | (almostfull & wr_en);

  fifo_arb_rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .enable (!rst && !blocked),
    .gnt    (pick_gnt),
    .win    (win),
    .valid  (pick_valid)
  );

  always_comb begin
    state = IDLE;
    if (pick_valid)  state = ISSUE;
    else if (|req)   state = STALL;
  end

  always_comb begin
    gnt = '0;
    if (state == ISSUE) gnt = pick_gnt;
  end

  assign next_cnt = (win == last_win) ? burst_cnt + 1'b1 : CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en     <= 1'b0;
      data_in   <= '0;
      rr_ptr    <= '0;
      last_win  <= '0;
      burst_cnt <= '0;
      exp_ack   <= 1'b0;
      err       <= 1'b0;
    end else begin
      wr_en   <= pick_valid;
      exp_ack <= wr_en;
      err     <= err | (exp_ack ^ wr_ack) | overflow;
      if (pick_valid) begin
        data_in  <= req_data[int'(win)*FIFO_WIDTH +: FIFO_WIDTH];
        last_win <= win;
        // Holding the pointer on the winner keeps priority until the burst limit.
        if (next_cnt == CW'(BURST_LEN)) begin
          rr_ptr    <= (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
          burst_cnt <= '0;
        end else begin
          rr_ptr    <= win;
          burst_cnt <= next_cnt;
        end
      end
    end
  end

`ifdef FIFO_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_gnt_cnt   <= '0;
      stat_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i] && stat_gnt_cnt[i*16 +: 16] != 16'hFFFF)
          stat_gnt_cnt[i*16 +: 16] <= stat_gnt_cnt[i*16 +: 16] + 16'd1;
      end
      if (state == STALL && stat_stall_cnt != 16'hFFFF)
        stat_stall_cnt <= stat_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: vector table plus multi-cycle sequences against a small FIFO model.
// Statistics checks are included when FIFO_ARB_STATS_EN is defined.
module tb_fifo_wr_arbiter;
  import fifo_wr_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] req_data;
  logic [3:0]  gnt;
  logic        wr_en;
  logic [15:0] data_in;
  logic        full, almostfull, wr_ack, overflow;
  logic        err;
`ifdef FIFO_ARB_STATS_EN
  logic [63:0] stat_gnt_cnt;
  logic [15:0] stat_stall_cnt;
`endif

  logic use_model, rd;
  logic d_full, d_af, d_ack, d_ovf;
  logic m_ack, m_ovf;
  int   m_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign full       = use_model ? (m_cnt == FIFO_DEPTH)     : d_full;
  assign almostfull = use_model ? (m_cnt == FIFO_DEPTH - 1) : d_af;
  assign wr_ack     = use_model ? m_ack : d_ack;
  assign overflow   = use_model ? m_ovf : d_ovf;

  // FIFO occupancy/response model: ack a write that fits, flag one that does not.
  always @(posedge clk) begin
    if (rst) begin
      m_cnt <= 0;
      m_ack <= 1'b0;
      m_ovf <= 1'b0;
    end else begin
      m_ack <= wr_en && (m_cnt < FIFO_DEPTH);
      m_ovf <= wr_en && (m_cnt == FIFO_DEPTH);
      m_cnt <= m_cnt + ((wr_en && m_cnt < FIFO_DEPTH) ? 1 : 0) - ((rd && m_cnt > 0) ? 1 : 0);
    end
  end

  fifo_wr_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .wr_en      (wr_en),
    .data_in    (data_in),
    .full       (full),
    .almostfull (almostfull),
    .wr_ack     (wr_ack),
    .overflow   (overflow),
    .err        (err)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_gnt_cnt   (stat_gnt_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic        full;
    logic        af;
    logic        ack;
    logic [3:0]  egnt;
    logic        ewr;
    logic [15:0] edata;
    logic        eerr;
  } vec_t;

  vec_t        vecs[18];
  logic [15:0] words[4];

  function automatic vec_t mk(logic r, logic [3:0] q, logic f, logic a, logic k,
                              logic [3:0] g, logic w, logic [15:0] d, logic e);
    vec_t v;
    v.rst = r; v.req = q; v.full = f; v.af = a; v.ack = k;
    v.egnt = g; v.ewr = w; v.edata = d; v.eerr = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int writes;
    logic ovf_seen;

    words[0] = 16'hA5A5; words[1] = 16'h1111; words[2] = 16'h2222; words[3] = 16'h3333;
    req_data = 64'h3333_2222_1111_A5A5;

    //            rst  req     full af   ack   gnt     wr    data      err
    vecs[0]  = mk(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 16'h0000, 1'b0);
    vecs[1]  = mk(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 16'h0000, 1'b0);
    vecs[2]  = mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 16'hA5A5, 1'b0);
    vecs[3]  = mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 16'hA5A5, 1'b0);
    vecs[4]  = mk(1'b0, 4'b1010, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 16'hA5A5, 1'b0);
    vecs[5]  = mk(1'b0, 4'b1010, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1, 16'h1111, 1'b0);
    vecs[6]  = mk(1'b0, 4'b1000, 1'b0, 1'b0, 1'b1, 4'b1000, 1'b1, 16'h1111, 1'b0);
    vecs[7]  = mk(1'b0, 4'b1001, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b1, 16'h3333, 1'b0);
    vecs[8]  = mk(1'b0, 4'b1001, 1'b0, 1'b1, 1'b1, 4'b1000, 1'b0, 16'h3333, 1'b0);
    vecs[9]  = mk(1'b0, 4'b1001, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 16'h3333, 1'b0);
    vecs[10] = mk(1'b0, 4'b1001, 1'b0, 1'b0, 1'b1, 4'b1000, 1'b0, 16'h3333, 1'b0);
    vecs[11] = mk(1'b0, 4'b1001, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, 16'h3333, 1'b0);
    vecs[12] = mk(1'b0, 4'b1000, 1'b0, 1'b0, 1'b1, 4'b1000, 1'b1, 16'h3333, 1'b0);
    vecs[13] = mk(1'b1, 4'b1000, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 16'h3333, 1'b0);
    vecs[14] = mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 16'h0000, 1'b0);
    vecs[15] = mk(1'b0, 4'b1010, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 16'h0000, 1'b0);
    vecs[16] = mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 16'h1111, 1'b0);
    vecs[17] = mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 16'h1111, 1'b0);

    rst = 1'b1; req = '0; use_model = 1'b0; rd = 1'b0;
    d_full = 1'b0; d_af = 1'b0; d_ack = 1'b0; d_ovf = 1'b0;
    repeat (3) @(negedge clk);

    // Table: each row's expected wr_en/data_in reflect the previous row's grant.
    for (int i = 0; i < 18; i++) begin
      rst = vecs[i].rst; req = vecs[i].req;
      d_full = vecs[i].full; d_af = vecs[i].af; d_ack = vecs[i].ack;
      #1;
      chk($sformatf("row%0d gnt", i),     64'(gnt),     64'(vecs[i].egnt));
      chk($sformatf("row%0d wr_en", i),   64'(wr_en),   64'(vecs[i].ewr));
      chk($sformatf("row%0d data_in", i), 64'(data_in), 64'(vecs[i].edata));
      chk($sformatf("row%0d err", i),     64'(err),     64'(vecs[i].eerr));
      @(negedge clk);
    end

    // Burst limit: all four requesting with the FIFO drained every cycle.
    rst = 1'b1; req = '0; d_ack = 1'b0; use_model = 1'b1; rd = 1'b1;
    @(negedge clk);
    rst = 1'b0; req = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      #1;
      chk($sformatf("burst gnt %0d", i), 64'(gnt), 64'(4'(1 << (i / 4))));
      if (i > 0) begin
        chk($sformatf("burst wr_en %0d", i), 64'(wr_en), 64'd1);
        chk($sformatf("burst data %0d", i), 64'(data_in), 64'(words[(i - 1) / 4]));
      end
      @(negedge clk);
    end
    req = '0;
    repeat (3) @(negedge clk);
    #1 chk("burst err", 64'(err), 64'd0);

    // Fill with no reads: exactly FIFO_DEPTH writes, then a clean stall.
    @(negedge clk);
    rst = 1'b1; rd = 1'b0;
    @(negedge clk);
    rst = 1'b0; req = 4'b0011; writes = 0; ovf_seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (wr_en) writes++;
      if (overflow) ovf_seen = 1'b1;
      @(negedge clk);
    end
    #1;
    chk("fill writes", 64'(writes), 64'(FIFO_DEPTH));
    chk("fill gnt", 64'(gnt), 64'd0);
    chk("fill full", 64'(full), 64'd1);
    chk("fill state", 64'(dut.state), 64'(STALL));
    chk("fill overflow", 64'(ovf_seen), 64'd0);
    chk("fill err", 64'(err), 64'd0);

    // Missing ack, overflow, and spurious ack each set the sticky error.
    @(negedge clk);
    use_model = 1'b0; d_full = 1'b0; d_af = 1'b0; d_ack = 1'b0; d_ovf = 1'b0;
    rst = 1'b1; req = '0;
    @(negedge clk);
    rst = 1'b0; req = 4'b0001;
    #1 chk("ack gnt", 64'(gnt), 64'b0001);
    @(negedge clk);
    req = '0;
    @(negedge clk);
    #1 chk("ack err before", 64'(err), 64'd0);
    @(negedge clk);
    #1 chk("missing ack err", 64'(err), 64'd1);
    repeat (3) @(negedge clk);
    #1 chk("missing ack sticky", 64'(err), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("err cleared", 64'(err), 64'd0);
    d_ovf = 1'b1;
    @(negedge clk);
    d_ovf = 1'b0;
    #1 chk("overflow err", 64'(err), 64'd1);
    repeat (2) @(negedge clk);
    #1 chk("overflow sticky", 64'(err), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; d_ack = 1'b1;
    @(negedge clk);
    d_ack = 1'b0;
    #1 chk("spurious ack err", 64'(err), 64'd1);

`ifdef FIFO_ARB_STATS_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req = 4'b0100;
    repeat (10) @(negedge clk);
    d_full = 1'b1;
    repeat (3) @(negedge clk);
    req = '0; d_full = 1'b0;
    @(negedge clk);
    #1;
    chk("stat gnt2", 64'(stat_gnt_cnt[47:32]), 64'd10);
    chk("stat gnt0", 64'(stat_gnt_cnt[15:0]), 64'd0);
    chk("stat stall", 64'(stat_stall_cnt), 64'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
